// File: rtl/relu_quant_drain_pkg.sv
// Shared types and default widths for the convolution engine's result drain.
package relu_quant_drain_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_SHIFT  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    READ,
    CAPT,
    SEND
  } state_e;
endpackage

// File: rtl/relu_quant.sv
// ReLU followed by right-shift requantisation with unsigned saturation.
module relu_quant
  import relu_quant_drain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic [DATA_W-1:0] x,
  output logic [OUT_W-1:0]  q
);
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] s;

  // r is non-negative after ReLU, so a logical shift equals the arithmetic one
  always_comb begin
    r = x[DATA_W-1] ? '0 : x;
    s = r >> SHIFT;
    q = (|s[DATA_W-1:OUT_W]) ? '1 : s[OUT_W-1:0];
  end
endmodule

// File: rtl/relu_quant_drain.sv
// Drains the engine result buffer after done, quantises each word and streams
// 8-bit activations out over valid/ready, one word per read/capture/send trip.
module relu_quant_drain
  import relu_quant_drain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] res_count,
  input  logic              done_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              drained
);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                drained_q, drained_d;
  logic                done_prev_q;
  logic [OUT_W-1:0]    q_val;
  logic                done_edge;
  logic                hs;

  relu_quant #(.DATA_W(DATA_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_quant (
    .x (mem_data),
    .q (q_val)
  );

  assign done_edge = done_in & ~done_prev_q;
  assign hs        = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    drained_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        count_d = res_count;
        addr_d  = '0;
        state_d = ARMED;
      end
      ARMED: if (done_edge) begin
        if (count_q == '0) begin
          drained_d = 1'b1;
          state_d   = IDLE;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = addr_q;
          state_d    = READ;
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        out_data_d  = q_val;
        out_valid_d = 1'b1;
        out_last_d  = (addr_q == count_q - ADDR_ONE);
        state_d     = SEND;
      end
      SEND: if (hs) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (out_last_q) begin
          drained_d = 1'b1;
          state_d   = IDLE;
        end else begin
          // mem_addr is registered alongside the read strobe so it only moves on a read
          addr_d     = addr_q + ADDR_ONE;
          mem_addr_d = addr_q + ADDR_ONE;
          mem_rd_d   = 1'b1;
          state_d    = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drained_q   <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      drained_q   <= drained_d;
      done_prev_q <= done_in;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign drained   = drained_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_relu_quant_drain.sv
// Randomised and directed checks of relu_quant_drain against a word-list model.
module tb_relu_quant_drain;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              done_in = 1'b0;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] res_count = '0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid, out_last, busy, drained;

  always #5 clk = ~clk;

  relu_quant_drain #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .start(start), .res_count(res_count), .done_in(done_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .drained(drained)
  );

  typedef struct { int data; bit last; } exp_t;
  exp_t exp_q[$];
  int   got_q[$];
  int   hs_cyc[$];
  logic [DATA_W-1:0] mem [0:4095];

  int n_cmp = 0, n_err = 0, cyc = 0, drain_cnt = 0;
  int rd_cnt = 0, exp_addr = 0, drain_cyc = 0, done_rise_cyc = 0;
  int first_rd_cyc = -1, first_vld_cyc = -1, rdy_mode = 0, stall = 0;
  bit chk_en = 0, expect_drain = 0, last_hs_prev = 0, hold_prev = 0, done_seen = 0;
  logic [OUT_W-1:0] hold_data;
  logic             hold_last;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int q_model(input logic [DATA_W-1:0] w);
    int x, v;
    x = $signed(w);
    if (x < 0) return 0;
    v = x / (1 << SHIFT);
    return (v > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : v;
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    case ($urandom_range(0, 3))
      0: return DATA_W'(-$urandom_range(1, 100000));
      1: return DATA_W'($urandom_range(0, 16'hFFFF));
      2: return DATA_W'($urandom_range(32'hFF00, 32'h100FF));
      default: return DATA_W'($urandom);
    endcase
  endfunction

  // Result buffer: data one cycle after the strobe, garbage otherwise
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : DATA_W'($urandom);

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && !out_ready) begin
          stall++;
          if (stall > 5) out_ready = 1'b1;
        end else begin
          out_ready = 1'b0;
          stall = 0;
        end
      end
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (done_in && !done_seen) done_rise_cyc = cyc;
    done_seen = done_in;
    if (chk_en) begin
      if (last_hs_prev) check("drained_after_last", drained, 1);
      last_hs_prev = 0;
      if (drained) begin
        check("drain_expected", expect_drain, 1);
        check("drain_queue_empty", exp_q.size(), 0);
        check("busy_at_drain", busy, 0);
        expect_drain = 0;
        drain_cnt++;
        drain_cyc = cyc;
      end
      if (mem_rd) begin
        check("mem_addr", mem_addr, exp_addr);
        exp_addr++;
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
      hold_prev = 0;
      if (out_valid) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (exp_q.size() == 0) check("spurious_valid", out_valid, 0);
        else if (out_ready) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
          got_q.push_back(int'(out_data));
          hs_cyc.push_back(cyc);
          if (e.last) last_hs_prev = 1;
        end else begin
          hold_prev = 1;
          hold_data = out_data;
          hold_last = out_last;
        end
      end
    end
  end

  task automatic start_job(input int cnt, input bit with_done);
    @(posedge clk); #1;
    res_count = ADDR_W'(cnt);
    start = 1'b1;
    if (with_done) done_in = 1'b1;
    for (int i = 0; i < cnt; i++) exp_q.push_back('{q_model(mem[i]), (i == cnt - 1)});
    got_q.delete();
    hs_cyc.delete();
    rd_cnt = 0;
    exp_addr = 0;
    first_rd_cyc = -1;
    first_vld_cyc = -1;
    expect_drain = 1;
    @(posedge clk); #1;
    start = 1'b0;
    res_count = ADDR_W'($urandom);
  endtask

  task automatic fire_done();
    @(posedge clk); #1;
    done_in = 1'b1;
  endtask

  task automatic finish_job(input int cnt, input string nm);
    int d0, n;
    d0 = drain_cnt;
    n = 0;
    while (drain_cnt == d0 && n < 40 * cnt + 40) begin
      @(posedge clk);
      n++;
    end
    check({nm, "_drained_once"}, drain_cnt - d0, 1);
    check({nm, "_reads"}, rd_cnt, cnt);
    check({nm, "_words"}, got_q.size(), cnt);
    @(posedge clk); #1;
    done_in = 1'b0;
  endtask

  task automatic fill(input int cnt);
    for (int i = 0; i < cnt; i++) mem[i] = rand_word();
  endtask

  initial begin
    int n;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_drained", drained, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk_en = 1;

    // Basic drain with pinned literal outputs, latency and throughput
    rdy_mode = 0;
    mem[0] = 32'hFFFF_FFFB; mem[1] = 32'h100; mem[2] = 32'h7F; mem[3] = 32'h12345;
    start_job(4, 0);
    fire_done();
    finish_job(4, "basic");
    if (got_q.size() == 4) begin
      check("basic_w0", got_q[0], 0);
      check("basic_w1", got_q[1], 1);
      check("basic_w2", got_q[2], 0);
      check("basic_w3", got_q[3], 255);
      for (int i = 1; i < 4; i++) check("basic_rate", hs_cyc[i] - hs_cyc[i-1], 3);
    end
    check("basic_rd_latency", first_rd_cyc - done_rise_cyc, 1);
    check("basic_vld_latency", first_vld_cyc - done_rise_cyc, 3);

    // Backpressure: five stalled cycles per word
    rdy_mode = 2;
    fill(2);
    start_job(2, 0);
    fire_done();
    finish_job(2, "bp");
    if (hs_cyc.size() == 2) check("bp_spacing", hs_cyc[1] - hs_cyc[0], 8);
    check("bp_first_wait", hs_cyc.size() > 0 ? hs_cyc[0] - first_vld_cyc : -1, 5);

    // Zero-count job drains with no reads
    rdy_mode = 0;
    start_job(0, 0);
    fire_done();
    finish_job(0, "zero");
    check("zero_drain_latency", drain_cyc - done_rise_cyc, 1);
    check("zero_busy", busy, 0);

    // Edge qualification: level already high does not trigger
    @(posedge clk); #1;
    done_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_edge_busy", busy, 0);
    fill(2);
    start_job(2, 0);
    repeat (4) @(posedge clk);
    #1;
    check("held_done_busy", busy, 1);
    check("held_done_reads", rd_cnt, 0);
    done_in = 1'b0;
    fire_done();
    finish_job(2, "edge");
    check("edge_rd_latency", first_rd_cyc - done_rise_cyc, 1);

    // start and done rising together in IDLE: only start is taken
    fill(1);
    start_job(1, 1);
    repeat (4) @(posedge clk);
    #1;
    check("same_cycle_busy", busy, 1);
    check("same_cycle_reads", rd_cnt, 0);
    done_in = 1'b0;
    fire_done();
    finish_job(1, "same");

    // Ignored start and done edge during a drain
    rdy_mode = 2;
    fill(4);
    start_job(4, 0);
    fire_done();
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #2; n++; end
    check("ign_reach_send", out_valid, 1);
    @(posedge clk); #1;
    start = 1'b1;
    res_count = ADDR_W'(9);
    done_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    done_in = 1'b1;
    finish_job(4, "ignored");
    repeat (2) @(posedge clk);
    #1;
    check("ignored_idle", busy, 0);

    // Random jobs with random backpressure
    rdy_mode = 1;
    for (int j = 0; j < 6; j++) begin
      int cnt;
      cnt = $urandom_range(1, 10);
      fill(cnt);
      start_job(cnt, 0);
      fire_done();
      finish_job(cnt, "rand");
    end

    // Reset during the third SEND aborts the stream
    rdy_mode = 0;
    fill(8);
    start_job(8, 0);
    fire_done();
    n = 0;
    while (!(got_q.size() == 2 && out_valid) && n < 100) begin @(posedge clk); #2; n++; end
    check("rst_reach_send3", out_valid, 1);
    chk_en = 0;
    #1 rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_last", out_last, 0);
    check("abort_mem_rd", mem_rd, 0);
    check("abort_busy", busy, 0);
    check("abort_drained", drained, 0);
    exp_q.delete();
    expect_drain = 0;
    hold_prev = 0;
    last_hs_prev = 0;
    done_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1;
    repeat (3) @(posedge clk);
    fill(1);
    start_job(1, 0);
    fire_done();
    finish_job(1, "post_rst");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/relu_quant_drain.md
Name: relu_quant_drain

Overview:
- Downstream stage of the convolution engine. It runs after the engine's done output rises.
- Reads the engine's result buffer word by word and applies ReLU, then a right-shift requantisation with saturation.
- Streams the 8-bit activations out on a valid/ready interface for the next layer or the host.
- Shares the top-level start with the engine. It arms on start and begins draining on the engine's done.

Parameters:
DATA_W, 32, width of a signed result word in the engine's buffer
ADDR_W, 12, result buffer address width; max words per job = 2^ADDR_W - 1
OUT_W, 8, unsigned output activation width
SHIFT, 8, arithmetic right shift applied after ReLU (0..DATA_W-1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  job start pulse (same net that starts the engine)
res_count  in  ADDR_W  number of result words for this job, sampled on accepted start
done_in  in  1  engine done (level); rising edge triggers drain
mem_rd  out  1  result-buffer read strobe
mem_addr  out  ADDR_W  result-buffer read address
mem_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd
out_data  out  OUT_W  quantised activation
out_valid  out  1  out_data valid
out_ready  in  1  consumer ready
out_last  out  1  high with out_valid on the final word of the job
busy  out  1  high in every state except IDLE
drained  out  1  1-cycle pulse when the job finishes

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_rd=0, mem_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, drained=0; done edge register=0; count=0.
- States:
  - IDLE: start=1 -> latch count=res_count, addr=0 -> ARMED.
  - ARMED: wait for a rising edge of done_in (done_in=1 and registered prev=0).
    - If count==0: drained=1 next cycle -> IDLE, and no reads are issued.
    - Otherwise -> READ.
  - READ: mem_rd=1 for one cycle with mem_addr=addr -> CAPT.
  - CAPT: register out_data=q(mem_data), out_valid=1, out_last=(addr==count-1) -> SEND.
  - SEND: hold out_data/out_valid/out_last stable until out_valid&out_ready.
    - On handshake with out_last=1: out_valid=0, drained=1 for one cycle -> IDLE.
    - On handshake otherwise: out_valid=0, addr=addr+1 -> READ.
- Quantisation q(x), combinational:
  - r = (x<0) ? 0 : x.
  - s = r >>> SHIFT.
  - q = (s > 2^OUT_W-1) ? 2^OUT_W-1 : s[OUT_W-1:0].
- Throughput: 1 word per 3 cycles with out_ready held high. Latency from the done_in edge cycle to the first out_valid is 3 cycles.
- start outside IDLE is ignored; res_count changes after latching are ignored.
- done_in rise while in IDLE or while draining is ignored. Only the edge seen in ARMED counts.
- done_in already high when ARMED is entered does not trigger a drain; a fresh rising edge is required.
- start and done_in rising in the same IDLE cycle: the start is taken and the edge is not.
- The edge register samples done_in every cycle regardless of state.
- mem_addr holds its last value when mem_rd=0.
- Reset asserted mid-job aborts immediately:
  - no drained pulse is produced;
  - any partially sent stream is discarded;
  - the consumer sees out_valid drop asynchronously.

Decomposition:
- Shared package: state encoding constants (IDLE, ARMED, READ, CAPT, SEND) and the default DATA_W/ADDR_W/OUT_W/SHIFT values used by the top-level and the engine.
- One sub-module, relu_quant: purely combinational q(x), parameterised on DATA_W, OUT_W, SHIFT.
- The FSM, counter and handshake stay in relu_quant_drain.

Test Plan:
- Basic drain: res_count=4, buffer={-5, 0x100, 0x7F, 0x12345}, out_ready=1, done_in rising -> out_data 0,1,0,255; out_last only on the 4th word; drained pulse 1 cycle after the 4th handshake.
- Backpressure: res_count=2, out_ready low 5 cycles on each word -> out_data/out_valid/out_last stable throughout; exactly 2 handshakes; mem_rd asserted exactly twice (addr 0, 1).
- Zero count: start with res_count=0, done_in rises -> no mem_rd, no out_valid, drained pulses once, busy returns to 0.
- Edge qualification: done_in high before start and held -> stays in ARMED with busy=1; done_in low then high -> drain starts with mem_rd 1 cycle later.
- Reset mid-stream: res_count=8, assert rst during the 3rd SEND -> all outputs 0 asynchronously, no drained pulse; a new start with res_count=1 then completes normally.
- Ignored events: a second start while in SEND and a second done_in edge during the drain -> no change to count, addr or number of output words.
